// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle RV32I controller: state encoding,
// opcodes, ALU control codes, datapath select codes and the immediate-format decode.
package multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_HALT     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  // 3'b100 (eq) belongs to the ALU encoding but is never requested by this controller.
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  function automatic logic [1:0] imm_src(input logic [6:0] op);
    logic [1:0] sel;
    case (op)
      OP_STORE: sel = IMM_S;
      OP_BEQ:   sel = IMM_B;
      OP_JAL:   sel = IMM_J;
      default:  sel = IMM_I;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_alu_decoder.sv
// ALU decoder: maps the controller's ALUOp plus instruction funct fields onto ALUControl.
module alu_decoder
  import multicycle_ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [2:0] alu_control
);

  // funct decode; op5 separates R-type sub from I-type addi, which has no sub form
  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000: begin
            if (op5 && funct7b5) alu_control = ALU_SUB;
            else                 alu_control = ALU_ADD;
          end
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle RV32I datapath: sequences fetch/decode/execute/
// memory/writeback and drives the datapath selects and write enables (Moore, from state).
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       illegal
);

  state_t     state_r;
  state_t     state_nxt_s;
  logic       pc_update_s;
  logic       branch_s;
  logic       adr_src_s;
  logic       mem_write_s;
  logic       ir_write_s;
  logic       reg_write_s;
  logic       halt_s;
  logic [1:0] result_src_s;
  logic [1:0] src_a_s;
  logic [1:0] src_b_s;
  logic [1:0] alu_op_s;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_r <= S_FETCH;
    else       state_r <= state_nxt_s;
  end

  // Next-state logic; any encoding outside the defined states recovers to FETCH
  always_comb begin
    state_nxt_s = S_FETCH;
    case (state_r)
      S_FETCH: state_nxt_s = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_nxt_s = S_MEMADR;
          OP_RTYPE:          state_nxt_s = S_EXECR;
          OP_ITYPE:          state_nxt_s = S_EXECI;
          OP_BEQ:            state_nxt_s = S_BEQ;
          OP_JAL:            state_nxt_s = S_JAL;
          default: begin
            if (HALT_ON_ILLEGAL) state_nxt_s = S_HALT;
            else                 state_nxt_s = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        if (op[5]) state_nxt_s = S_MEMWRITE;
        else       state_nxt_s = S_MEMREAD;
      end
      S_MEMREAD:  state_nxt_s = S_MEMWB;
      S_MEMWB:    state_nxt_s = S_FETCH;
      S_MEMWRITE: state_nxt_s = S_FETCH;
      S_EXECR:    state_nxt_s = S_ALUWB;
      S_EXECI:    state_nxt_s = S_ALUWB;
      S_ALUWB:    state_nxt_s = S_FETCH;
      S_BEQ:      state_nxt_s = S_FETCH;
      S_JAL:      state_nxt_s = S_ALUWB;
      S_HALT:     state_nxt_s = S_HALT;
      default:    state_nxt_s = S_FETCH;
    endcase
  end

  // Moore output decode from the current state
  always_comb begin
    pc_update_s  = 1'b0;
    branch_s     = 1'b0;
    adr_src_s    = 1'b0;
    mem_write_s  = 1'b0;
    ir_write_s   = 1'b0;
    reg_write_s  = 1'b0;
    halt_s       = 1'b0;
    result_src_s = RES_ALUOUT;
    src_a_s      = SRCA_PC;
    src_b_s      = SRCB_RS2;
    alu_op_s     = ALUOP_ADD;
    case (state_r)
      S_FETCH: begin
        ir_write_s   = 1'b1;
        pc_update_s  = 1'b1;
        src_b_s      = SRCB_FOUR;
        result_src_s = RES_ALURESULT;
      end
      S_DECODE: begin
        src_a_s = SRCA_OLDPC;
        src_b_s = SRCB_IMM;
      end
      S_MEMADR: begin
        src_a_s = SRCA_RS1;
        src_b_s = SRCB_IMM;
      end
      S_MEMREAD: adr_src_s = 1'b1;
      S_MEMWB: begin
        result_src_s = RES_DATA;
        reg_write_s  = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src_s   = 1'b1;
        mem_write_s = 1'b1;
      end
      S_EXECR: begin
        src_a_s  = SRCA_RS1;
        alu_op_s = ALUOP_FUNCT;
      end
      S_EXECI: begin
        src_a_s  = SRCA_RS1;
        src_b_s  = SRCB_IMM;
        alu_op_s = ALUOP_FUNCT;
      end
      S_ALUWB: reg_write_s = 1'b1;
      S_BEQ: begin
        src_a_s  = SRCA_RS1;
        alu_op_s = ALUOP_SUB;
        branch_s = 1'b1;
      end
      S_JAL: begin
        src_a_s     = SRCA_OLDPC;
        src_b_s     = SRCB_FOUR;
        pc_update_s = 1'b1;
      end
      S_HALT:  halt_s = 1'b1;
      default: halt_s = 1'b0;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op_s),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .op5         (op[5]),
    .alu_control (ALUControl)
  );

  // Enables are masked by reset so an instruction aborted by reset never writes
  assign PCWrite   = ~reset & (pc_update_s | (branch_s & zero));
  assign IRWrite   = ~reset & ir_write_s;
  assign RegWrite  = ~reset & reg_write_s;
  assign MemWrite  = ~reset & mem_write_s;
  assign illegal   = ~reset & halt_s;
  assign AdrSrc    = adr_src_s;
  assign ResultSrc = result_src_s;
  assign ALUSrcA   = src_a_s;
  assign ALUSrcB   = src_b_s;
  assign ImmSrc    = imm_src(op);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: a cycle-by-cycle vector table of instruction
// sequences, then hand-written HALT / illegal-opcode / reset-recovery sequences.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] op = 7'b0110011;
  logic [2:0] funct3 = 3'b000;
  logic       funct7b5 = 1'b0;
  logic       zero = 1'b0;

  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;

  logic       d0_pcw, d0_adr, d0_memw, d0_irw, d0_regw, d0_ill;
  logic [1:0] d0_res, d0_sa, d0_sb, d0_imm;
  logic [2:0] d0_aluc;

  int checks = 0;
  int failures = 0;

  localparam logic [6:0] LW   = 7'b0000011;
  localparam logic [6:0] SW   = 7'b0100011;
  localparam logic [6:0] RT   = 7'b0110011;
  localparam logic [6:0] IT   = 7'b0010011;
  localparam logic [6:0] BEQ  = 7'b1100011;
  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] ILL  = 7'b1111111;

  typedef struct {
    logic        rst;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic        z;
    logic [16:0] exp;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  multicycle_ctrl #(.HALT_ON_ILLEGAL(1'b1)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ImmSrc(ImmSrc), .ALUControl(ALUControl), .illegal(illegal)
  );

  multicycle_ctrl #(.HALT_ON_ILLEGAL(1'b0)) dut0 (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
    .PCWrite(d0_pcw), .AdrSrc(d0_adr), .MemWrite(d0_memw), .IRWrite(d0_irw),
    .RegWrite(d0_regw), .ResultSrc(d0_res), .ALUSrcA(d0_sa), .ALUSrcB(d0_sb),
    .ImmSrc(d0_imm), .ALUControl(d0_aluc), .illegal(d0_ill)
  );

  // Bundle layout: pcw adr memw irw regw res[2] srca[2] srcb[2] imm[2] aluc[3] ill
  function automatic logic [16:0] e(input logic pcw, input logic adr, input logic memw,
                                    input logic irw, input logic regw, input logic [1:0] res,
                                    input logic [1:0] sa, input logic [1:0] sb,
                                    input logic [1:0] imm, input logic [2:0] aluc,
                                    input logic ill);
    return {pcw, adr, memw, irw, regw, res, sa, sb, imm, aluc, ill};
  endfunction

  function automatic logic [16:0] act1();
    return {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB,
            ImmSrc, ALUControl, illegal};
  endfunction

  function automatic logic [16:0] act0();
    return {d0_pcw, d0_adr, d0_memw, d0_irw, d0_regw, d0_res, d0_sa, d0_sb,
            d0_imm, d0_aluc, d0_ill};
  endfunction

  task automatic row(input logic rst, input logic [6:0] o, input logic [2:0] f3,
                     input logic f7, input logic z, input logic [16:0] ex);
    vec_t v;
    v.rst = rst; v.op = o; v.f3 = f3; v.f7 = f7; v.z = z; v.exp = ex;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [16:0] act, input logic [16:0] ex);
    checks++;
    if (act !== ex) begin
      failures++;
      $display("FAIL %s actual=%05h expected=%05h", name, act, ex);
    end
  endtask

  task automatic drive(input logic rst, input logic [6:0] o, input logic [2:0] f3,
                       input logic f7, input logic z);
    reset = rst; op = o; funct3 = f3; funct7b5 = f7; zero = z;
    #1;
  endtask

  initial begin
    // reset (2 cycles) then R-type sub
    row(1'b1, RT, 3'b000, 1'b1, 1'b0, e(0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,3'b000,0));
    row(1'b1, RT, 3'b000, 1'b1, 1'b0, e(0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,3'b000,0));
    row(1'b0, RT, 3'b000, 1'b1, 1'b0, e(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0));
    row(1'b0, RT, 3'b000, 1'b1, 1'b0, e(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0));
    row(1'b0, RT, 3'b000, 1'b1, 1'b0, e(0,0,0,0,0,2'b00,2'b10,2'b00,2'b00,3'b001,0));
    row(1'b0, RT, 3'b000, 1'b1, 1'b0, e(0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,3'b000,0));
    // lw: 5 cycles
    row(1'b0, LW, 3'b010, 1'b0, 1'b0, e(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0));
    row(1'b0, LW, 3'b010, 1'b0, 1'b0, e(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0));
    row(1'b0, LW, 3'b010, 1'b0, 1'b0, e(0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b000,0));
    row(1'b0, LW, 3'b010, 1'b0, 1'b0, e(0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0));
    row(1'b0, LW, 3'b010, 1'b0, 1'b0, e(0,0,0,0,1,2'b01,2'b00,2'b00,2'b00,3'b000,0));
    // sw: 4 cycles, one MemWrite pulse
    row(1'b0, SW, 3'b010, 1'b0, 1'b0, e(1,0,0,1,0,2'b10,2'b00,2'b10,2'b01,3'b000,0));
    row(1'b0, SW, 3'b010, 1'b0, 1'b0, e(0,0,0,0,0,2'b00,2'b01,2'b01,2'b01,3'b000,0));
    row(1'b0, SW, 3'b010, 1'b0, 1'b0, e(0,0,0,0,0,2'b00,2'b10,2'b01,2'b01,3'b000,0));
    row(1'b0, SW, 3'b010, 1'b0, 1'b0, e(0,1,1,0,0,2'b00,2'b00,2'b00,2'b01,3'b000,0));
    // beq taken, then not taken: 3 cycles each
    row(1'b0, BEQ, 3'b000, 1'b0, 1'b1, e(1,0,0,1,0,2'b10,2'b00,2'b10,2'b10,3'b000,0));
    row(1'b0, BEQ, 3'b000, 1'b0, 1'b1, e(0,0,0,0,0,2'b00,2'b01,2'b01,2'b10,3'b000,0));
    row(1'b0, BEQ, 3'b000, 1'b0, 1'b1, e(1,0,0,0,0,2'b00,2'b10,2'b00,2'b10,3'b001,0));
    row(1'b0, BEQ, 3'b000, 1'b0, 1'b0, e(1,0,0,1,0,2'b10,2'b00,2'b10,2'b10,3'b000,0));
    row(1'b0, BEQ, 3'b000, 1'b0, 1'b0, e(0,0,0,0,0,2'b00,2'b01,2'b01,2'b10,3'b000,0));
    row(1'b0, BEQ, 3'b000, 1'b0, 1'b0, e(0,0,0,0,0,2'b00,2'b10,2'b00,2'b10,3'b001,0));
    // ori then slti
    row(1'b0, IT, 3'b110, 1'b0, 1'b0, e(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0));
    row(1'b0, IT, 3'b110, 1'b0, 1'b0, e(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0));
    row(1'b0, IT, 3'b110, 1'b0, 1'b0, e(0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b011,0));
    row(1'b0, IT, 3'b110, 1'b0, 1'b0, e(0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,3'b000,0));
    row(1'b0, IT, 3'b010, 1'b1, 1'b0, e(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0));
    row(1'b0, IT, 3'b010, 1'b1, 1'b0, e(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0));
    row(1'b0, IT, 3'b010, 1'b1, 1'b0, e(0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b101,0));
    row(1'b0, IT, 3'b010, 1'b1, 1'b0, e(0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,3'b000,0));
    // jal: 4 cycles
    row(1'b0, JAL, 3'b000, 1'b0, 1'b0, e(1,0,0,1,0,2'b10,2'b00,2'b10,2'b11,3'b000,0));
    row(1'b0, JAL, 3'b000, 1'b0, 1'b0, e(0,0,0,0,0,2'b00,2'b01,2'b01,2'b11,3'b000,0));
    row(1'b0, JAL, 3'b000, 1'b0, 1'b0, e(1,0,0,0,0,2'b00,2'b01,2'b10,2'b11,3'b000,0));
    row(1'b0, JAL, 3'b000, 1'b0, 1'b0, e(0,0,0,0,1,2'b00,2'b00,2'b00,2'b11,3'b000,0));
    // addi with funct7b5=1 stays add (op[5]=0)
    row(1'b0, IT, 3'b000, 1'b1, 1'b0, e(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0));
    row(1'b0, IT, 3'b000, 1'b1, 1'b0, e(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0));
    row(1'b0, IT, 3'b000, 1'b1, 1'b0, e(0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b000,0));
    row(1'b0, IT, 3'b000, 1'b1, 1'b0, e(0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,3'b000,0));
    // R-type and
    row(1'b0, RT, 3'b111, 1'b0, 1'b0, e(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0));
    row(1'b0, RT, 3'b111, 1'b0, 1'b0, e(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0));
    row(1'b0, RT, 3'b111, 1'b0, 1'b0, e(0,0,0,0,0,2'b00,2'b10,2'b00,2'b00,3'b010,0));
    row(1'b0, RT, 3'b111, 1'b0, 1'b0, e(0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,3'b000,0));
    // sw aborted by reset in MEMWRITE, then restart from FETCH
    row(1'b0, SW, 3'b010, 1'b0, 1'b0, e(1,0,0,1,0,2'b10,2'b00,2'b10,2'b01,3'b000,0));
    row(1'b0, SW, 3'b010, 1'b0, 1'b0, e(0,0,0,0,0,2'b00,2'b01,2'b01,2'b01,3'b000,0));
    row(1'b0, SW, 3'b010, 1'b0, 1'b0, e(0,0,0,0,0,2'b00,2'b10,2'b01,2'b01,3'b000,0));
    row(1'b1, SW, 3'b010, 1'b0, 1'b0, e(0,1,0,0,0,2'b00,2'b00,2'b00,2'b01,3'b000,0));
    row(1'b0, SW, 3'b010, 1'b0, 1'b0, e(1,0,0,1,0,2'b10,2'b00,2'b10,2'b01,3'b000,0));

    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].z);
      check($sformatf("vec%0d", i), act1(), vecs[i].exp);
      check($sformatf("vec%0d_nohalt", i), act0(), vecs[i].exp);
      @(negedge clk);
    end

    // Illegal opcode: HALT for the default instance, straight back to FETCH otherwise
    drive(1'b1, ILL, 3'b000, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b0, ILL, 3'b000, 1'b0, 1'b0);
    check("ill_fetch_irw", {16'd0, IRWrite}, 17'd1);
    @(negedge clk);
    drive(1'b0, ILL, 3'b000, 1'b0, 1'b0);
    check("ill_decode_ill", {16'd0, illegal}, 17'd0);
    @(negedge clk);
    drive(1'b0, ILL, 3'b000, 1'b0, 1'b0);
    check("nohalt_back_to_fetch", {15'd0, d0_irw, d0_ill}, 17'd2);
    for (int k = 0; k < 20; k++) begin
      drive(1'b0, ILL, 3'b000, 1'b0, 1'b0);
      check($sformatf("halt_cyc%0d", k),
            {12'd0, PCWrite, MemWrite, IRWrite, RegWrite, illegal}, 17'd1);
      @(negedge clk);
    end
    drive(1'b1, ILL, 3'b000, 1'b0, 1'b0);
    check("halt_reset_ill", {16'd0, illegal}, 17'd0);
    @(negedge clk);
    drive(1'b0, RT, 3'b000, 1'b0, 1'b0);
    check("halt_recover_fetch", {14'd0, PCWrite, IRWrite, illegal}, 17'd6);
    @(negedge clk);
    drive(1'b0, RT, 3'b000, 1'b0, 1'b0);
    check("halt_recover_decode", {12'd0, IRWrite, ALUSrcA, ALUSrcB}, 17'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
